// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the TX arbiter and serial core
//
// Purpose : state enums for the arbiter and bit FSMs, frame width constant and
//           the clocks-per-bit helper used by the arbiter to size the core.
// Ports   : none (package).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic {
    IDLE,
    SEND
  } arb_state_t;

  typedef enum logic [1:0] {
    START,
    DATA,
    STOP
  } core_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 serialiser: shifter, baud counter and bit FSM
//
// Purpose : takes one byte on start while idle and shifts it out as
//           start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT clocks.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           start, tx_byte - load request and byte, honoured only while idle
//           tx             - registered serial output, idle high
//           busy           - a frame is in flight
//           done           - high during the final clock of the stop bit
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  core_state_t          state, state_n;
  logic                 active, active_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_q, tx_n;
  logic                 bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= START;
      active <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      tx_q   <= 1'b1;
    end else begin
      state  <= state_n;
      active <= active_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      tx_q   <= tx_n;
    end
  end

  // tx is computed one clock ahead so the pin is driven straight from a flop.
  always_comb begin
    state_n  = state;
    active_n = active;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    tx_n     = tx_q;
    bit_end  = (cnt == LAST_TICK);
    if (!active) begin
      if (start) begin
        active_n = 1'b1;
        state_n  = START;
        cnt_n    = '0;
        idx_n    = '0;
        shreg_n  = tx_byte;
        tx_n     = 1'b0;
      end
    end else if (!bit_end) begin
      cnt_n = cnt + CW'(1);
    end else begin
      cnt_n = '0;
      case (state)
        START: begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
        DATA: begin
          // idx wraps 7 -> 0 on the way out of DATA
          idx_n = idx + 3'd1;
          if (idx == LAST_BIT) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            tx_n = shreg[idx_n];
          end
        end
        STOP: begin
          state_n  = START;
          active_n = 1'b0;
          tx_n     = 1'b1;
        end
        default: begin
          state_n  = START;
          active_n = 1'b0;
          tx_n     = 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = active;
  assign done = active && (state == STOP) && bit_end;

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin two-requester arbiter driving one 8N1 TX pin
//
// Purpose : grants one byte at a time to port 0 (CPU MMIO) or port 1 (debug
//           stream), alternating under contention, and hands it to uart_tx_core.
// Config  : UART_ARB_LOCK_EN - when defined, the current owner holding its lock
//           keeps the grant; otherwise lock0/lock1 are ignored.
// Ports   : CLK, reset        - clock, asynchronous active-high reset
//           valid0/1, data0/1 - requester byte offers
//           ready0/1          - accept strobes, at most one high per cycle
//           lock0/1           - ownership hold requests
//           tx                - serial line, idle high
//           busy              - a frame is in flight
//           owner             - last granted requester (1 after reset)
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 valid0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ready0,
  input  logic                 lock0,
  input  logic                 valid1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ready1,
  input  logic                 lock1,
  output logic                 tx,
  output logic                 busy,
  output logic                 owner
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_arb: CLK_HZ/BAUD must be at least 2");
  end

  arb_state_t           state, state_n;
  logic                 pick;
  logic                 owner_lock;
  logic                 start;
  logic                 done;
  logic [DATA_BITS-1:0] tx_byte;

`ifdef UART_ARB_LOCK_EN
  assign owner_lock = owner ? lock1 : lock0;
`else
  assign owner_lock = 1'b0;
  logic unused_lock;
  assign unused_lock = lock0 | lock1;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b1;
    end else begin
      state <= state_n;
      if (start) owner <= pick;
    end
  end

  always_comb begin
    pick    = 1'b0;
    state_n = state;
    // A locked owner keeps the grant even with its valid low, which stalls
    // the other port until the lock drops.
    if (owner_lock)
      pick = owner;
    else if (valid0 && valid1)
      pick = !owner;
    else if (valid1)
      pick = 1'b1;
    // reset gates the readies so nothing is accepted while reset is held
    ready0  = (state == IDLE) && !reset && valid0 && !pick;
    ready1  = (state == IDLE) && !reset && valid1 && pick;
    start   = ready0 || ready1;
    tx_byte = pick ? data1 : data0;
    case (state)
      IDLE:    if (start) state_n = SEND;
      SEND:    if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (CLK),
    .rst    (reset),
    .start  (start),
    .tx_byte(tx_byte),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

endmodule
